// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - request/card bundle between a deal requester and card_dealer
interface card_dealer_if;
  logic       deal_req;
  logic       shuffle;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_empty;

  modport master (
    output deal_req, shuffle,
    input  card_valid, card_rank, card_suit, card_value, busy, cards_left, deck_empty
  );

  modport slave (
    input  deal_req, shuffle,
    output card_valid, card_rank, card_suit, card_value, busy, cards_left, deck_empty
  );
endinterface

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals unique cards from a 52-card deck using LFSR draws with a scan fallback
module card_dealer #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          REJECT_LIMIT = 16
) (
  input logic          CLOCK_50,
  input logic          reset,
  card_dealer_if.slave dbus
);
  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam int          REJ_W = (REJECT_LIMIT < 1) ? 1 : $clog2(REJECT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAW, SCAN} state_t;

  state_t             state, state_n;
  logic [15:0]        lfsr, lfsr_n;
  logic [51:0]        used;
  logic [5:0]         cards_left;
  logic [REJ_W-1:0]   rej_cnt;
  logic               card_valid;
  logic [3:0]         card_rank, card_suit_pad, card_value;
  logic [1:0]         card_suit;

  logic [63:0]        used_ext;
  logic [5:0]         cand, scan_idx, acc_idx;
  logic               cand_ok, scan_found, accept, rej_inc;
  logic [1:0]         acc_suit;
  logic [3:0]         acc_rank, acc_value;

  assign lfsr_n   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign used_ext = {12'h000, used};
  assign cand     = lfsr[5:0];
  assign cand_ok  = (cand < 6'd52) && !used_ext[cand];

  // Lowest unused index wins: later (lower) iterations overwrite higher ones.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = 6'd0;
    for (int i = 51; i >= 0; i--) begin
      if (!used[i]) begin
        scan_found = 1'b1;
        scan_idx   = 6'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    rej_inc = 1'b0;
    acc_idx = cand;
    case (state)
      IDLE: if (dbus.deal_req && cards_left != 6'd0) state_n = DRAW;
      DRAW: begin
        if (cand_ok) begin
          accept  = 1'b1;
          state_n = IDLE;
        end else begin
          rej_inc = 1'b1;
          if (int'(rej_cnt) + 1 >= REJECT_LIMIT) state_n = SCAN;
        end
      end
      SCAN: begin
        accept  = scan_found;
        acc_idx = scan_idx;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (dbus.shuffle) begin
      state_n = IDLE;
      accept  = 1'b0;
      rej_inc = 1'b0;
    end
  end

  always_comb begin
    acc_suit = 2'd0;
    acc_rank = 4'(acc_idx + 6'd1);
    if (acc_idx >= 6'd39) begin
      acc_suit = 2'd3;
      acc_rank = 4'(acc_idx - 6'd38);
    end else if (acc_idx >= 6'd26) begin
      acc_suit = 2'd2;
      acc_rank = 4'(acc_idx - 6'd25);
    end else if (acc_idx >= 6'd13) begin
      acc_suit = 2'd1;
      acc_rank = 4'(acc_idx - 6'd12);
    end
    if (acc_rank == 4'd1)       acc_value = 4'd11;
    else if (acc_rank > 4'd10)  acc_value = 4'd10;
    else                        acc_value = acc_rank;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lfsr       <= SEED;
      used       <= '0;
      cards_left <= 6'd52;
      rej_cnt    <= '0;
      card_valid <= 1'b0;
      card_rank  <= 4'd0;
      card_suit  <= 2'd0;
      card_value <= 4'd0;
    end else begin
      lfsr       <= lfsr_n;
      card_valid <= accept;
      if (dbus.shuffle) begin
        used       <= '0;
        cards_left <= 6'd52;
        rej_cnt    <= '0;
      end else if (accept) begin
        used       <= used | (52'd1 << acc_idx);
        cards_left <= cards_left - 6'd1;
        rej_cnt    <= '0;
        card_rank  <= acc_rank;
        card_suit  <= acc_suit;
        card_value <= acc_value;
      end else if (rej_inc) begin
        rej_cnt <= rej_cnt + REJ_W'(1);
      end
    end
  end

  assign card_suit_pad   = {2'b00, card_suit};
  assign dbus.card_valid = card_valid;
  assign dbus.card_rank  = card_rank;
  assign dbus.card_suit  = card_suit_pad[1:0];
  assign dbus.card_value = card_value;
  assign dbus.busy       = (state != IDLE);
  assign dbus.cards_left = cards_left;
  assign dbus.deck_empty = (cards_left == 6'd0);
endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - randomized self-checking bench for card_dealer against a deck/LFSR model
module tb_card_dealer;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  card_dealer_if dif ();

  card_dealer #(.LFSR_SEED(SEED), .REJECT_LIMIT(16)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .dbus     (dif.slave)
  );

  always #10 clk = ~clk;

  logic [15:0] m_lfsr;
  bit          m_used [64];
  bit          dut_seen [64];
  int          m_left;
  int          gaps [52];
  int          rec [52];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = SEED;
    else       m_lfsr = lfsr_adv(m_lfsr);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_used[i]   = 1'b0;
      dut_seen[i] = 1'b0;
    end
    m_left = 52;
  endtask

  // Up to 16 random attempts in successive cycles, otherwise the lowest free card one cycle later.
  task automatic predict(input logic [15:0] l0, output int idx, output int lat);
    logic [15:0] l;
    bit found;
    l = l0;
    found = 1'b0;
    idx = -1;
    lat = 18;
    for (int k = 1; k <= 16; k++) begin
      l = lfsr_adv(l);
      if (!found && int'(l[5:0]) < 52 && !m_used[l[5:0]]) begin
        found = 1'b1;
        idx = int'(l[5:0]);
        lat = k + 1;
      end
    end
    if (!found) begin
      for (int i = 51; i >= 0; i--) if (!m_used[i]) idx = i;
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_card_valid", int'(dif.card_valid), 0);
    check_eq("rst_card_rank", int'(dif.card_rank), 0);
    check_eq("rst_card_suit", int'(dif.card_suit), 0);
    check_eq("rst_card_value", int'(dif.card_value), 0);
    check_eq("rst_busy", int'(dif.busy), 0);
    check_eq("rst_deck_empty", int'(dif.deck_empty), 0);
    check_eq("rst_cards_left", int'(dif.cards_left), 52);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic deal_one(output int got_idx);
    int exp_idx, exp_lat, lat, r, s, er;
    predict(m_lfsr, exp_idx, exp_lat);
    dif.deal_req = 1'b1;
    tick();
    dif.deal_req = 1'b0;
    lat = 1;
    while (!dif.card_valid && lat < 30) begin
      check_eq("busy_while_drawing", int'(dif.busy), 1);
      tick();
      lat++;
    end
    check_eq("deal_valid_seen", int'(dif.card_valid), 1);
    check_eq("deal_latency", lat, exp_lat);
    check_eq("latency_bound", int'(lat <= 18), 1);
    s = int'(dif.card_suit);
    r = int'(dif.card_rank);
    got_idx = s * 13 + r - 1;
    er = exp_idx % 13 + 1;
    check_eq("card_idx", got_idx, exp_idx);
    check_eq("rank_range", int'(r >= 1 && r <= 13), 1);
    check_eq("card_value", int'(dif.card_value), (er == 1) ? 11 : ((er > 10) ? 10 : er));
    if (got_idx >= 0 && got_idx < 52) begin
      check_eq("card_distinct", int'(dut_seen[got_idx]), 0);
      dut_seen[got_idx] = 1'b1;
    end
    if (exp_idx >= 0) m_used[exp_idx] = 1'b1;
    m_left--;
    check_eq("cards_left", int'(dif.cards_left), m_left);
    check_eq("busy_at_valid", int'(dif.busy), 0);
  endtask

  task automatic do_shuffle();
    dif.shuffle = 1'b1;
    tick();
    dif.shuffle = 1'b0;
    model_clear();
  endtask

  initial begin
    int idx;
    dif.deal_req = 1'b0;
    dif.shuffle  = 1'b0;
    reset        = 1'b1;
    model_clear();
    idle_cycles(3);
    reset = 1'b0;
    check_reset_outputs();

    // Full deck with random gaps; sequence recorded for the post-reset replay.
    for (int i = 0; i < 52; i++) begin
      gaps[i] = int'($urandom_range(0, 3));
      idle_cycles(gaps[i]);
      deal_one(idx);
      rec[i] = idx;
    end
    check_eq("final_cards_left", int'(dif.cards_left), 0);
    check_eq("final_deck_empty", int'(dif.deck_empty), 1);

    dif.deal_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("empty_no_valid", int'(dif.card_valid), 0);
      check_eq("empty_busy", int'(dif.busy), 0);
      check_eq("empty_cards_left", int'(dif.cards_left), 0);
    end
    dif.deal_req = 1'b0;

    do_shuffle();
    check_eq("shuffle_cards_left", int'(dif.cards_left), 52);
    for (int i = 0; i < 10; i++) begin
      idle_cycles(int'($urandom_range(0, 2)));
      deal_one(idx);
    end
    dif.deal_req = 1'b1;
    tick();
    dif.deal_req = 1'b0;
    check_eq("abort_busy_before", int'(dif.busy), 1);
    do_shuffle();
    check_eq("abort_no_valid", int'(dif.card_valid), 0);
    check_eq("abort_cards_left", int'(dif.cards_left), 52);
    check_eq("abort_busy", int'(dif.busy), 0);
    tick();
    check_eq("abort_no_late_valid", int'(dif.card_valid), 0);
    for (int i = 0; i < 52; i++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      deal_one(idx);
    end
    check_eq("redeal_deck_empty", int'(dif.deck_empty), 1);

    do_shuffle();
    for (int i = 0; i < 12; i++) deal_one(idx);
    check_eq("forty_left", int'(dif.cards_left), 40);
    dif.deal_req = 1'b1;
    dif.shuffle  = 1'b1;
    tick();
    dif.deal_req = 1'b0;
    dif.shuffle  = 1'b0;
    model_clear();
    check_eq("both_cards_left", int'(dif.cards_left), 52);
    check_eq("both_no_valid", int'(dif.card_valid), 0);
    check_eq("both_busy", int'(dif.busy), 0);
    tick();
    check_eq("both_stays_idle", int'(dif.busy), 0);
    check_eq("both_no_late_valid", int'(dif.card_valid), 0);

    for (int i = 0; i < 3; i++) deal_one(idx);
    dif.deal_req = 1'b1;
    tick();
    dif.deal_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    check_reset_outputs();
    for (int i = 0; i < 10; i++) begin
      idle_cycles(gaps[i]);
      deal_one(idx);
      check_eq("replay_matches_powerup", idx, rec[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
